// File: rtl/ncsp_mash_pkg.sv
// ncsp_mash_pkg: shared state encoding, field widths and reset constants
package ncsp_mash_pkg;
    typedef enum logic [2:0] {IDLE, RST, SETTLE, RUN, PHASE} state_e;
    localparam int FRAC_W  = 8;
    localparam int SEED_W  = 12;
    localparam int ORDER_W = 2;
    localparam int PHASE_W = 12;
    localparam logic [SEED_W-1:0]  SEED_RST  = 12'h001;
    localparam logic [ORDER_W-1:0] ORDER_RST = 2'b00;
endpackage

// File: rtl/ncsp_mash_ctrl_if.sv
// ncsp_mash_ctrl_if: configuration handshake, phase request and MASH config bus
interface ncsp_mash_ctrl_if;
    import ncsp_mash_pkg::*;
    logic               i_cfg_valid;
    logic               o_cfg_ready;
    logic               i_cfg_reseed;
    logic [FRAC_W-1:0]  i_cfg_msb, i_cfg_isb, i_cfg_lsb, i_cfg_int;
    logic [ORDER_W-1:0] i_cfg_order;
    logic [SEED_W-1:0]  i_cfg_seed;
    logic               i_phase_req;
    logic [PHASE_W-1:0] i_phaseadd;
    logic               o_phase_ack;
    logic [FRAC_W-1:0]  o_msb, o_isb, o_lsb, o_int;
    logic [SEED_W-1:0]  o_seed;
    logic [ORDER_W-1:0] o_sel_order;
    logic [PHASE_W-1:0] o_phaseadd;
    logic               o_mashreseten, o_phaseadjusten, o_sel_frac, o_running, o_busy;
    modport master (
        output i_cfg_valid, i_cfg_reseed, i_cfg_msb, i_cfg_isb, i_cfg_lsb, i_cfg_int,
               i_cfg_order, i_cfg_seed, i_phase_req, i_phaseadd,
        input  o_cfg_ready, o_phase_ack, o_msb, o_isb, o_lsb, o_int, o_seed, o_sel_order,
               o_phaseadd, o_mashreseten, o_phaseadjusten, o_sel_frac, o_running, o_busy
    );
    modport slave (
        input  i_cfg_valid, i_cfg_reseed, i_cfg_msb, i_cfg_isb, i_cfg_lsb, i_cfg_int,
               i_cfg_order, i_cfg_seed, i_phase_req, i_phaseadd,
        output o_cfg_ready, o_phase_ack, o_msb, o_isb, o_lsb, o_int, o_seed, o_sel_order,
               o_phaseadd, o_mashreseten, o_phaseadjusten, o_sel_frac, o_running, o_busy
    );
endinterface

// File: rtl/ncsp_mash_ctrl_cnt.sv
// ncsp_mash_ctrl_cnt: loadable down-counter with zero flag; holds at zero
module ncsp_mash_ctrl_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign zero_o = cnt_q == '0;
    always_comb cnt_d = load_i ? val_i : (dec_i && !zero_o) ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
endmodule

// File: rtl/ncsp_mash_ctrl.sv
// ncsp_mash_ctrl: cold-start sequencing, glitch-free hops and phase-adjust pulses
// for the NCSP MASH DDSM; all outputs are registers or state decodes.
module ncsp_mash_ctrl import ncsp_mash_pkg::*; #(
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int PHASE_PULSE   = 2,
    parameter int CNT_W         = 8
) (
    input logic i_clk,
    input logic i_rst_n,
    ncsp_mash_ctrl_if.slave bus
);
    state_e             state_q, state_d;
    logic               accept, load, dec, zero, cap_all, cap_frac, cap_ph, ack_q, ack_d;
    logic [CNT_W-1:0]   load_val;
    logic [FRAC_W-1:0]  msb_q, isb_q, lsb_q, int_q;
    logic [SEED_W-1:0]  seed_q;
    logic [ORDER_W-1:0] order_q;
    logic [PHASE_W-1:0] padd_q;

    assign bus.o_cfg_ready = state_q inside {IDLE, RUN};
    assign accept = bus.i_cfg_valid && bus.o_cfg_ready;
    assign dec    = state_q inside {RST, SETTLE, PHASE};
    assign ack_d  = state_q == PHASE && zero;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        cap_all  = 1'b0;
        cap_frac = 1'b0;
        cap_ph   = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                // a cold start from IDLE ignores reseed; in RUN it selects restart vs hop
                if (accept && (state_q == IDLE || bus.i_cfg_reseed)) begin
                    state_d  = RST;
                    load     = 1'b1;
                    load_val = CNT_W'(RST_CYCLES - 1);
                    cap_all  = 1'b1;
                end else if (accept) begin
                    cap_frac = 1'b1;
                end else if (state_q == RUN && bus.i_phase_req && !ack_q) begin
                    state_d  = PHASE;
                    load     = 1'b1;
                    load_val = CNT_W'(PHASE_PULSE - 1);
                    cap_ph   = 1'b1;
                end
            end
            RST: begin
                state_d  = zero ? SETTLE : RST;
                load     = zero;
                load_val = CNT_W'(SETTLE_CYCLES - 1);
            end
            SETTLE:  state_d = zero ? RUN : SETTLE;
            PHASE:   state_d = zero ? RUN : PHASE;
            default: state_d = IDLE;
        endcase
    end

    ncsp_mash_ctrl_cnt #(.W(CNT_W)) u_cnt (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .load_i (load),
        .dec_i  (dec),
        .val_i  (load_val),
        .zero_o (zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            msb_q   <= '0;
            isb_q   <= '0;
            lsb_q   <= '0;
            int_q   <= '0;
            seed_q  <= SEED_RST;
            order_q <= ORDER_RST;
            padd_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            if (cap_all || cap_frac) begin
                msb_q <= bus.i_cfg_msb;
                isb_q <= bus.i_cfg_isb;
                lsb_q <= bus.i_cfg_lsb;
                int_q <= bus.i_cfg_int;
            end
            if (cap_all) begin
                seed_q  <= bus.i_cfg_seed;
                order_q <= bus.i_cfg_order;
            end
            if (cap_ph) padd_q <= bus.i_phaseadd;
        end
    end

    assign bus.o_msb           = msb_q;
    assign bus.o_isb           = isb_q;
    assign bus.o_lsb           = lsb_q;
    assign bus.o_int           = int_q;
    assign bus.o_seed          = seed_q;
    assign bus.o_sel_order     = order_q;
    assign bus.o_phaseadd      = padd_q;
    assign bus.o_phase_ack     = ack_q;
    assign bus.o_mashreseten   = state_q inside {IDLE, RST};
    assign bus.o_phaseadjusten = state_q == PHASE;
    assign bus.o_sel_frac      = state_q inside {RUN, PHASE};
    assign bus.o_running       = state_q == RUN;
    assign bus.o_busy          = state_q inside {RST, SETTLE, PHASE};
endmodule

// File: tb/tb_ncsp_mash_ctrl.sv
// tb_ncsp_mash_ctrl: timeline reference model feeds an expected-output queue;
// a negedge monitor pops and compares the full output vector every cycle.
module tb_ncsp_mash_ctrl;
    localparam int RSTC = 4;
    localparam int SETC = 16;
    localparam int PP   = 2;

    typedef struct packed {
        logic       ready, ack;
        logic [7:0] msb, isb, lsb, intw;
        logic [11:0] seed;
        logic [1:0] order;
        logic [11:0] padd;
        logic       rsten, padj, selfrac, run, busy;
    } vec_t;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    ncsp_mash_ctrl_if bus();

    ncsp_mash_ctrl #(.RST_CYCLES(RSTC), .SETTLE_CYCLES(SETC), .PHASE_PULSE(PP), .CNT_W(8)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    vec_t sb[$];
    vec_t got, mon_e, m, e;
    int   checks = 0, passes = 0;
    bit   started;
    int   n, a, p, k;
    bit   run_pre, ph_pre, ack_pre, rdy_pre, run_now, ph_now;

    assign got = {bus.o_cfg_ready, bus.o_phase_ack, bus.o_msb, bus.o_isb, bus.o_lsb, bus.o_int,
                  bus.o_seed, bus.o_sel_order, bus.o_phaseadd, bus.o_mashreseten,
                  bus.o_phaseadjusten, bus.o_sel_frac, bus.o_running, bus.o_busy};

    function automatic vec_t rst_vec();
        vec_t v = '0;
        v.ready = 1'b1;
        v.rsten = 1'b1;
        v.seed  = 12'h001;
        return v;
    endfunction

    // a = edge of the last cold accept, p = edge that entered the phase pulse
    initial forever begin
        @(posedge i_clk or negedge i_rst_n);
        if (!i_rst_n) begin
            started = 0; n = 0; a = 0; p = -100;
            m = rst_vec();
            sb.delete();
            sb.push_back(rst_vec());
        end else begin
            n++;
            k       = n - 1 - a;
            run_pre = started && k >= RSTC + SETC;
            ph_pre  = run_pre && (n - 1 - p) >= 0 && (n - 1 - p) < PP;
            ack_pre = run_pre && (n - 1) == p + PP;
            rdy_pre = !started || (run_pre && !ph_pre);
            if (bus.i_cfg_valid && rdy_pre) begin
                m.msb = bus.i_cfg_msb; m.isb = bus.i_cfg_isb;
                m.lsb = bus.i_cfg_lsb; m.intw = bus.i_cfg_int;
                if (!started || bus.i_cfg_reseed) begin
                    started = 1; a = n; p = -100;
                    m.seed = bus.i_cfg_seed; m.order = bus.i_cfg_order;
                end
            end else if (run_pre && !ph_pre && bus.i_phase_req && !ack_pre) begin
                p = n;
                m.padd = bus.i_phaseadd;
            end
            k       = n - a;
            run_now = started && k >= RSTC + SETC;
            ph_now  = run_now && (n - p) >= 0 && (n - p) < PP;
            e         = m;
            e.ready   = !started || (run_now && !ph_now);
            e.ack     = run_now && n == p + PP;
            e.rsten   = !started || k < RSTC;
            e.padj    = ph_now;
            e.selfrac = run_now;
            e.run     = run_now && !ph_now;
            e.busy    = started && !(run_now && !ph_now);
            sb.push_back(e);
        end
    end

    initial forever begin
        @(negedge i_clk);
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (got === mon_e) passes++;
            else $display("FAIL outvec t=%0t got=%h exp=%h", $time, got, mon_e);
        end
    end

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s got=%h exp=%h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int c);
        repeat (c) tick();
    endtask

    task automatic cfg(input bit rs, input logic [7:0] msb, isb, lsb, iw,
                       input logic [1:0] ord, input logic [11:0] sd);
        bus.i_cfg_reseed = rs;
        bus.i_cfg_msb = msb; bus.i_cfg_isb = isb; bus.i_cfg_lsb = lsb; bus.i_cfg_int = iw;
        bus.i_cfg_order = ord; bus.i_cfg_seed = sd;
        bus.i_cfg_valid = 1'b1;
        tick();
        bus.i_cfg_valid = 1'b0;
    endtask

    task automatic phase(input logic [11:0] pa, input bit hop);
        bit seen = 0;
        bus.i_phase_req = 1'b1;
        bus.i_phaseadd  = pa;
        if (hop) begin
            bus.i_cfg_reseed = 1'b0;
            bus.i_cfg_msb = 8'h5A; bus.i_cfg_isb = 8'hC3; bus.i_cfg_lsb = 8'h0F; bus.i_cfg_int = 8'd12;
            bus.i_cfg_order = 2'b10; bus.i_cfg_seed = 12'hFFF;
            bus.i_cfg_valid = 1'b1;
        end
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            bus.i_cfg_valid = 1'b0;
            if (bus.o_phase_ack) seen = 1;
        end
        bus.i_phase_req = 1'b0;
        checks++;
        if (seen) passes++;
        else $display("FAIL phase_ack_timeout got=0 exp=1");
    endtask

    initial begin
        bit req_on = 0;
        bus.i_cfg_valid = 0; bus.i_cfg_reseed = 0; bus.i_cfg_msb = 0; bus.i_cfg_isb = 0;
        bus.i_cfg_lsb = 0; bus.i_cfg_int = 0; bus.i_cfg_order = 0; bus.i_cfg_seed = 0;
        bus.i_phase_req = 0; bus.i_phaseadd = 0;
        idle(3);
        i_rst_n = 1'b1;
        idle(2);
        cfg(0, 8'h80, 8'h40, 8'h20, 8'd10, 2'b11, 12'hA5A);
        idle(25);
        cfg(0, 8'hFF, 8'h40, 8'h20, 8'd11, 2'b00, 12'h777);
        idle(3);
        phase(12'h123, 0);
        idle(3);
        phase(12'h456, 1);
        idle(3);
        cfg(1, 8'h01, 8'h02, 8'h03, 8'h04, 2'b01, 12'h001);
        idle(25);
        cfg(1, 8'h11, 8'h22, 8'h33, 8'h44, 2'b10, 12'h3C3);
        idle(8);
        #2 i_rst_n = 1'b0;
        #1 chk("async_rst", got, rst_vec());
        idle(2);
        i_rst_n = 1'b1;
        idle(5);
        for (int i = 0; i < 600; i++) begin
            bus.i_cfg_valid  = $urandom_range(0, 5) == 0;
            bus.i_cfg_reseed = $urandom_range(0, 3) == 0;
            bus.i_cfg_msb = 8'($urandom); bus.i_cfg_isb = 8'($urandom);
            bus.i_cfg_lsb = 8'($urandom); bus.i_cfg_int = 8'($urandom);
            bus.i_cfg_order = 2'($urandom); bus.i_cfg_seed = 12'($urandom);
            if (req_on && bus.o_phase_ack) begin
                bus.i_phase_req = 1'b0;
                req_on = 0;
            end else if (!req_on && $urandom_range(0, 4) == 0) begin
                bus.i_phase_req = 1'b1;
                bus.i_phaseadd  = 12'($urandom);
                req_on = 1;
            end
            tick();
        end
        bus.i_cfg_valid = 0;
        bus.i_phase_req = 0;
        idle(3);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
